not_gate_4bit: RTL and testbench

- Bitwise inverter for the integer ALU logic-unit slice: drives o = ~x combinationally, with zero latency.
- Also provides a registered copy of the inverted value and a one-cycle change pulse, so downstream pipelined ALU stages can sample a stable result.
- The combinational path is the primary function and does not depend on clock or reset.

---
 rtl/not_gate_4bit.sv | 38 +++
 tb/tb_not_gate_4bit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/not_gate_4bit.sv
// Bitwise inverter: combinational o = ~x, plus a registered copy and a
// one-cycle pulse flagging each change of the registered value.
module not_gate_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
  output logic             o_chg
);

  logic [WIDTH-1:0] inv_d, inv_q;
  logic             chg_d, chg_q;

  assign o = ~x;

  always_comb begin
    inv_d = ~x;
    chg_d = (inv_d != inv_q);
  end

  // Reset value is the inverse of a zero operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= '1;
      chg_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
      chg_q <= chg_d;
    end
  end

  assign o_q   = inv_q;
  assign o_chg = chg_q;

endmodule

// File: tb/tb_not_gate_4bit.sv
// Self-checking bench for not_gate_4bit at WIDTH=4 and WIDTH=8 against an
// arithmetic reference model (~x == 2**W-1 - x).
module tb_not_gate_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] x4;
  logic [3:0] o4, o_q4;
  logic       o_chg4;
  logic [7:0] x8;
  logic [7:0] o8, o_q8;
  logic       o_chg8;

  int unsigned total;
  int unsigned bad;

  logic [3:0] m4_q;
  logic       m4_chg;
  logic [7:0] m8_q;
  logic       m8_chg;

  not_gate_4bit #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .x    (x4),
    .o    (o4),
    .o_q  (o_q4),
    .o_chg(o_chg4)
  );

  not_gate_4bit #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .x    (x8),
    .o    (o8),
    .o_q  (o_q8),
    .o_chg(o_chg8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [3:0] inv4(input logic [3:0] v);
    return 4'(15 - int'(v));
  endfunction

  function automatic logic [7:0] inv8(input logic [7:0] v);
    return 8'(255 - int'(v));
  endfunction

  // Advance the model over one rising edge, then step past it to sample.
  task automatic tick();
    logic [3:0] n4;
    logic [7:0] n8;
    n4 = inv4(x4);
    n8 = inv8(x8);
    if (rst) begin
      m4_q = 4'd15; m4_chg = 1'b0;
      m8_q = 8'd255; m8_chg = 1'b0;
    end else begin
      m4_chg = (n4 != m4_q); m4_q = n4;
      m8_chg = (n8 != m8_q); m8_q = n8;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_sweep();
    logic [3:0] vals [3];
    vals[0] = 4'b0000; vals[1] = 4'b0110; vals[2] = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      x4 = vals[i];
      #1;
      total++;
      if (o4 !== inv4(vals[i])) begin
        bad++;
        $display("FAIL comb_sweep x=%b: o=%b expected %b", vals[i], o4, inv4(vals[i]));
      end
      #9;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x4  = 4'b0110;
    x8  = 8'h00;
    tick();
    tick();
    total++;
    if (o_q4 !== 4'b1111 || o_chg4 !== 1'b0) begin
      bad++;
      $display("FAIL reset: o_q=%b o_chg=%b expected 1111 0", o_q4, o_chg4);
    end
    total++;
    if (o4 !== 4'b1001) begin
      bad++;
      $display("FAIL reset_comb: o=%b expected 1001", o4);
    end
  endtask

  task automatic test_registered();
    rst = 1'b0;
    x4  = 4'b0110;
    tick();
    total++;
    if (o_q4 !== 4'b1001 || o_chg4 !== 1'b1 || o_q4 !== m4_q) begin
      bad++;
      $display("FAIL reg_release: o_q=%b o_chg=%b expected 1001 1", o_q4, o_chg4);
    end
    tick();
    total++;
    if (o_q4 !== 4'b1001 || o_chg4 !== 1'b0 || o_chg4 !== m4_chg) begin
      bad++;
      $display("FAIL reg_hold: o_q=%b o_chg=%b expected 1001 0", o_q4, o_chg4);
    end
  endtask

  task automatic test_change_pulse();
    logic [3:0] xs  [4];
    logic [3:0] eq  [4];
    logic       ech [4];
    xs[0] = 4'b0000; xs[1] = 4'b1111; xs[2] = 4'b1111; xs[3] = 4'b0101;
    eq[0] = 4'b1111; eq[1] = 4'b0000; eq[2] = 4'b0000; eq[3] = 4'b1010;
    ech[0] = 1'b0;   ech[1] = 1'b1;   ech[2] = 1'b0;   ech[3] = 1'b1;
    rst = 1'b1;
    x4  = 4'b0000;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x4 = xs[i];
      tick();
      total++;
      if (o_q4 !== eq[i] || o_chg4 !== ech[i]) begin
        bad++;
        $display("FAIL change_pulse step%0d: o_q=%b o_chg=%b expected %b %b",
                 i, o_q4, o_chg4, eq[i], ech[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    x4  = 4'b0101;
    #1;
    total++;
    if (o4 !== 4'b1010) begin
      bad++;
      $display("FAIL midreset_comb_pre: o=%b expected 1010", o4);
    end
    tick();
    total++;
    if (o_q4 !== 4'b1111 || o_chg4 !== 1'b0 || o4 !== 4'b1010) begin
      bad++;
      $display("FAIL midreset_assert: o_q=%b o_chg=%b o=%b expected 1111 0 1010", o_q4, o_chg4, o4);
    end
    rst = 1'b0;
    tick();
    total++;
    if (o_q4 !== 4'b1010 || o_chg4 !== 1'b1 || o4 !== 4'b1010) begin
      bad++;
      $display("FAIL midreset_release: o_q=%b o_chg=%b o=%b expected 1010 1 1010", o_q4, o_chg4, o4);
    end
  endtask

  task automatic test_exhaustive();
    rst = 1'b0;
    for (int v = 0; v < 16; v++) begin
      x4 = 4'(v);
      #1;
      total++;
      if (o4 !== inv4(4'(v))) begin
        bad++;
        $display("FAIL exhaustive_comb x=%0d: o=%b expected %b", v, o4, inv4(4'(v)));
      end
      tick();
      total++;
      if (o_q4 !== inv4(4'(v)) || o_q4 !== m4_q || o_chg4 !== m4_chg) begin
        bad++;
        $display("FAIL exhaustive_reg x=%0d: o_q=%b o_chg=%b expected %b %b",
                 v, o_q4, o_chg4, m4_q, m4_chg);
      end
    end
  endtask

  task automatic test_width8();
    rst = 1'b1;
    x8  = 8'hA5;
    #1;
    total++;
    if (o8 !== 8'h5A) begin
      bad++;
      $display("FAIL w8_comb: o=%h expected 5a", o8);
    end
    tick();
    total++;
    if (o_q8 !== 8'hFF || o_chg8 !== 1'b0) begin
      bad++;
      $display("FAIL w8_reset: o_q=%h o_chg=%b expected ff 0", o_q8, o_chg8);
    end
    rst = 1'b0;
    tick();
    total++;
    if (o_q8 !== 8'h5A || o_chg8 !== 1'b1) begin
      bad++;
      $display("FAIL w8_release: o_q=%h o_chg=%b expected 5a 1", o_q8, o_chg8);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 15) == 0);
      // Bias toward repeats so the no-change case is exercised often.
      if ($urandom_range(0, 2) != 0) begin
        x4 = 4'($urandom);
        x8 = 8'($urandom);
      end
      #1;
      total++;
      if (o4 !== inv4(x4) || o8 !== inv8(x8)) begin
        bad++;
        $display("FAIL random_comb n=%0d: o4=%b o8=%h expected %b %h", n, o4, o8, inv4(x4), inv8(x8));
      end
      tick();
      total++;
      if (o_q4 !== m4_q || o_chg4 !== m4_chg || o_q8 !== m8_q || o_chg8 !== m8_chg) begin
        bad++;
        $display("FAIL random_reg n=%0d: o_q4=%b chg4=%b o_q8=%h chg8=%b expected %b %b %h %b",
                 n, o_q4, o_chg4, o_q8, o_chg8, m4_q, m4_chg, m8_q, m8_chg);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    x4    = '0;
    x8    = '0;
    m4_q  = '0; m4_chg = 1'b0;
    m8_q  = '0; m8_chg = 1'b0;
    #2;
    test_comb_sweep();
    @(negedge clk);
    test_reset();
    test_registered();
    test_change_pulse();
    test_reset_midstream();
    test_exhaustive();
    test_width8();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
